// File: rtl/dump_sequencer.sv
// Walks the collector through every register word, then every data-memory word,
// and streams each word to the UART MSB byte first, one byte per tx_done handshake.
module dump_sequencer #(
    parameter int len    = 32,
    parameter int N_REGS = 32,
    parameter int N_MEM  = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [len-1:0] data_in,
    input  logic           tx_done,
    output logic           restart_col,
    output logic           enable_next,
    output logic           send_regs,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    output logic           busy,
    output logic           done
);

    localparam int NBYTES    = len / 8;
    localparam int MAX_WORDS = (N_REGS > N_MEM) ? N_REGS : N_MEM;
    localparam int WCW       = $clog2(MAX_WORDS + 1);
    localparam int BCW       = $clog2(NBYTES + 1);

    localparam logic [WCW-1:0] REG_LAST  = WCW'(N_REGS - 1);
    localparam logic [WCW-1:0] MEM_LAST  = WCW'(N_MEM - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    localparam logic PH_REG = 1'b0;
    localparam logic PH_MEM = 1'b1;

    logic [2:0]     state_q, state_d;
    logic           phase_q, phase_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [len-1:0] shift_q, shift_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    phase_d    = PH_REG;
                    word_cnt_d = '0;
                end
            end
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // The collector's registered output is valid one cycle after FETCH.
                shift_d    = data_in;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt_q != BYTE_LAST) begin
                        shift_d    = shift_q << 8;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        state_d    = S_SEND;
                    end else if (phase_q == PH_REG && word_cnt_q == REG_LAST) begin
                        // Collector keeps separate address counters, so no second restart.
                        phase_d    = PH_MEM;
                        word_cnt_d = '0;
                        state_d    = S_FETCH;
                    end else if (phase_q == PH_MEM && word_cnt_q == MEM_LAST) begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                        state_d    = S_FINISH;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_REG;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Every output comes from state or a register, never straight from an input.
    assign restart_col = (state_q == S_CLEAR);
    assign enable_next = (state_q == S_FETCH);
    assign tx_start    = (state_q == S_SEND);
    assign done        = (state_q == S_FINISH);
    assign busy        = (state_q != S_IDLE);
    assign send_regs   = (state_q != S_IDLE) && (phase_q == PH_REG);
    assign tx_data     = shift_q[len-1 -: 8];

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: collector and UART models plus a
// word-list reference that predicts the byte stream of a whole dump.
module tb_dump_sequencer;

    localparam int LEN = 32;
    localparam int NR  = 2;
    localparam int NM  = 1;
    localparam int NB  = LEN / 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           tx_done = 1'b0;
    logic [LEN-1:0] data_in = '0;
    logic           restart_col, enable_next, send_regs, tx_start, busy, done;
    logic [7:0]     tx_data;

    dump_sequencer #(.len(LEN), .N_REGS(NR), .N_MEM(NM)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .tx_done(tx_done),
        .restart_col(restart_col), .enable_next(enable_next), .send_regs(send_regs),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Collector contents and bench-side bookkeeping
    logic [LEN-1:0] regs_m [NR];
    logic [LEN-1:0] mem_m [NM];
    int             reg_a = 0, mem_a = 0;
    bit             pend = 0;
    logic [LEN-1:0] pend_w = '0;
    int             tx_timer = 0;
    int             tx_delay = 3;
    bit             spurious_en = 0;
    logic [7:0]     got_q[$];
    logic           got_sr_q[$];
    logic [7:0]     exp_q[$];
    int             en_cnt, tx_cnt, done_cnt, restart_cnt;
    int             first_restart, first_en, first_tx;
    logic           first_en_sr;
    int             wait_viol;
    bit             in_wait = 0;
    logic [7:0]     wait_byte = '0;

    // Monitor + collector + UART model, all evaluated on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (pend) begin
                data_in = pend_w;
                pend = 0;
            end
            if (restart_col === 1'b1) begin
                reg_a = 0;
                mem_a = 0;
                restart_cnt++;
                if (first_restart < 0) first_restart = cyc;
            end
            if (enable_next === 1'b1) begin
                en_cnt++;
                got_sr_q.push_back(send_regs);
                if (first_en < 0) begin
                    first_en = cyc;
                    first_en_sr = send_regs;
                end
                if (send_regs) begin
                    pend_w = regs_m[reg_a % NR];
                    reg_a++;
                end else begin
                    pend_w = mem_m[mem_a % NM];
                    mem_a++;
                end
                pend = 1;
                data_in = $urandom;
            end
            if (in_wait) begin
                if (tx_start !== 1'b0 || tx_data !== wait_byte) wait_viol++;
            end
            if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) begin
                    tx_done = 1'b1;
                    in_wait = 0;
                end
            end
            if (tx_start === 1'b1) begin
                got_q.push_back(tx_data);
                tx_cnt++;
                if (first_tx < 0) first_tx = cyc;
                tx_timer = tx_delay;
                in_wait = 1;
                wait_byte = tx_data;
            end
            if (done === 1'b1) done_cnt++;
            if (spurious_en && (tx_start === 1'b1 || enable_next === 1'b1)) tx_done = 1'b1;
        end
    end

    task automatic clear_logs();
        got_q.delete();
        got_sr_q.delete();
        en_cnt = 0; tx_cnt = 0; done_cnt = 0; restart_cnt = 0;
        first_restart = -1; first_en = -1; first_tx = -1; first_en_sr = 1'bx;
        wait_viol = 0;
    endtask

    task automatic randomize_words();
        for (int i = 0; i < NR; i++) regs_m[i] = $urandom;
        for (int i = 0; i < NM; i++) mem_m[i] = $urandom;
    endtask

    // Reference: all register words then all memory words, each MSB byte first
    task automatic build_expected();
        logic [LEN-1:0] w;
        exp_q.delete();
        for (int i = 0; i < NR + NM; i++) begin
            w = (i < NR) ? regs_m[i] : mem_m[i - NR];
            for (int b = 0; b < NB; b++) exp_q.push_back(w[LEN-1-8*b -: 8]);
        end
    endtask

    function automatic int byte_errors();
        int e = 0;
        if (got_q.size() != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic pulse_start(output int c0);
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit jitter_start);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            if (jitter_start) start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
        end
        start = 1'b0;
        chk_cnt++;
        if (done_cnt == 0) $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
        else pass_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({restart_col, enable_next, send_regs, tx_start, busy, done, tx_data} !== 14'd0)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {restart_col, enable_next, send_regs, tx_start, busy, done, tx_data});
        else pass_cnt++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || send_regs !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b send_regs=%b expected 0/0", busy, send_regs);
        else pass_cnt++;
    endtask

    task automatic test_start_timing();
        int c0;
        randomize_words();
        clear_logs();
        pulse_start(c0);
        wait_done("timing", 0);
        chk_cnt++;
        if (first_restart !== c0 + 1) $display("FAIL restart_cycle: got %0d expected %0d", first_restart, c0 + 1);
        else pass_cnt++;
        chk_cnt++;
        if (first_en !== c0 + 2 || first_en_sr !== 1'b1)
            $display("FAIL enable_cycle: got cyc %0d sr %b expected cyc %0d sr 1", first_en, first_en_sr, c0 + 2);
        else pass_cnt++;
        chk_cnt++;
        if (first_tx !== c0 + 4) $display("FAIL tx_start_cycle: got %0d expected %0d", first_tx, c0 + 4);
        else pass_cnt++;
    endtask

    task automatic test_byte_order();
        int c0;
        randomize_words();
        regs_m[0] = 32'hA1B2C3D4;
        build_expected();
        clear_logs();
        pulse_start(c0);
        wait_done("byte_order", 0);
        chk_cnt++;
        if (got_q.size() < 4 || {got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'hA1B2C3D4)
            $display("FAIL byte_order: got %0d bytes, first word %h expected a1b2c3d4",
                     got_q.size(), (got_q.size() >= 4) ? {got_q[0], got_q[1], got_q[2], got_q[3]} : 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_full_dump(input string name);
        int c0;
        int e;
        randomize_words();
        build_expected();
        clear_logs();
        pulse_start(c0);
        wait_done(name, 0);
        chk_cnt++;
        if (tx_cnt !== (NR + NM) * NB) $display("FAIL %s_tx_count: got %0d expected %0d", name, tx_cnt, (NR + NM) * NB);
        else pass_cnt++;
        chk_cnt++;
        if (en_cnt !== NR + NM || got_sr_q.size() != 3 || got_sr_q[0] !== 1'b1 || got_sr_q[1] !== 1'b1 || got_sr_q[2] !== 1'b0)
            $display("FAIL %s_enable_seq: got %0d pulses expected %0d with send_regs 1,1,0", name, en_cnt, NR + NM);
        else pass_cnt++;
        e = byte_errors();
        chk_cnt++;
        if (e != 0) $display("FAIL %s_bytes: got %0d byte errors expected 0", name, e);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt !== 1 || busy !== 1'b0)
            $display("FAIL %s_done: got %0d done pulses busy=%b expected 1 and 0", name, done_cnt, busy);
        else pass_cnt++;
    endtask

    task automatic test_spurious();
        int c0;
        int e;
        randomize_words();
        build_expected();
        clear_logs();
        spurious_en = 1;
        pulse_start(c0);
        wait_done("spurious", 1);
        spurious_en = 0;
        e = byte_errors();
        chk_cnt++;
        if (e != 0 || tx_cnt !== 12) $display("FAIL spurious_bytes: got %0d bytes %0d errors expected 12 and 0", tx_cnt, e);
        else pass_cnt++;
        chk_cnt++;
        if (restart_cnt !== 1 || en_cnt !== 3 || done_cnt !== 1)
            $display("FAIL spurious_counts: got restart %0d enable %0d done %0d expected 1 3 1", restart_cnt, en_cnt, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_tx_delay();
        int c0;
        int e;
        randomize_words();
        build_expected();
        clear_logs();
        tx_delay = 50;
        pulse_start(c0);
        wait_done("tx_delay", 0);
        tx_delay = 3;
        chk_cnt++;
        if (wait_viol !== 0) $display("FAIL wait_tx_hold: got %0d violations expected 0", wait_viol);
        else pass_cnt++;
        e = byte_errors();
        chk_cnt++;
        if (e != 0 || tx_cnt !== 12) $display("FAIL tx_delay_bytes: got %0d bytes %0d errors expected 12 and 0", tx_cnt, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_dump();
        int c0;
        int n = 0;
        randomize_words();
        clear_logs();
        pulse_start(c0);
        while (tx_cnt < NB + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (tx_cnt < NB + 2) $display("FAIL mid_reset_reach: got %0d bytes expected %0d", tx_cnt, NB + 2);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({restart_col, enable_next, send_regs, tx_start, busy, done, tx_data} !== 14'd0)
            $display("FAIL mid_reset_outputs: got %b expected all zero",
                     {restart_col, enable_next, send_regs, tx_start, busy, done, tx_data});
        else pass_cnt++;
        reset = 1'b1;
        tx_timer = 0;
        in_wait = 0;
        repeat (20) @(negedge clk);
        chk_cnt++;
        if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL mid_reset_abort: got done %0d busy %b expected 0 0", done_cnt, busy);
        else pass_cnt++;
        test_full_dump("after_reset");
        chk_cnt++;
        if (restart_cnt !== 1 || first_restart < 0) $display("FAIL after_reset_restart: got %0d restart pulses expected 1", restart_cnt);
        else pass_cnt++;
    endtask

    initial begin
        clear_logs();
        randomize_words();
        test_reset();
        test_start_timing();
        test_byte_order();
        test_full_dump("full");
        test_spurious();
        test_tx_delay();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
